stream_width_packer: RTL and testbench
======================================

STREAM_WIDTH_PACKER -- requirements
Module: stream_width_packer

Interface
REQ-001 Parameter DSIZE, default 8: input data width; matches the async FIFO data width.
REQ-002 Parameter RATIO, default 4: input beats per output word; legal values 2..16.
REQ-003 Parameter TIMEOUT, default 255: idle cycles before an automatic flush; 0 disables the timeout; maximum 65535.
REQ-004 The block SHALL have one clock; reset is asynchronous and active-low. Port rclk, input, 1: the clock, which is the FIFO read-domain clock.
REQ-005 Port rst_n, input, 1: asynchronous active-low reset.
REQ-006 Port rdata, input, DSIZE: byte from the FIFO read port.
REQ-007 Port r_ok, input, 1: rdata valid, driven by the FIFO.
REQ-008 Port r_en, output, 1: packer ready; drives the FIFO read enable.
REQ-009 Port flush, input, 1: single-cycle request to emit the partial word.
REQ-010 Port o_data, output, DSIZE*RATIO: packed word.
REQ-011 Port o_keep, output, RATIO: lane-valid mask.
REQ-012 Port o_last, output, 1: word was closed by flush or timeout.
REQ-013 Port o_valid, output, 1: output word valid.
REQ-014 Port o_ready, input, 1: downstream accepts the word.

Function
REQ-015 An input beat SHALL transfer on a rising rclk when r_ok and r_en are both 1; an output word SHALL transfer when o_valid and o_ready are both 1.
REQ-016 Accepted beats SHALL fill lanes in order starting at lane 0 (o_data[DSIZE-1:0]). A lane counter cnt (0..RATIO-1) SHALL track the next lane to fill.
REQ-017 out_free is defined as ~o_valid | o_ready.
REQ-018 r_en SHALL equal ~flush_pend & ((cnt != RATIO-1) | out_free) and SHALL be purely combinational.
REQ-019 The beat that fills lane RATIO-1 SHALL load the output register the same cycle: o_keep all ones, o_last 0, o_valid 1 on the next cycle. cnt SHALL wrap to 0. Full throughput is 1 beat per cycle with no bubble at the wrap.
REQ-020 The output register SHALL hold o_data, o_keep and o_last stable while o_valid=1 and o_ready=0.
REQ-021 A flush with cnt != 0 SHALL set flush_pend. A flush with cnt == 0 SHALL be ignored; no empty word is ever emitted.
REQ-022 While flush_pend=1 and out_free=1, the partial word SHALL load with o_keep = (1<<cnt)-1 and o_last=1; unused lanes SHALL be zero. cnt and flush_pend SHALL then clear.
REQ-023 The idle counter SHALL increment each cycle while cnt != 0, no beat is accepted and flush_pend=0. It SHALL reset to 0 on any accepted beat or when cnt == 0.
REQ-024 When the idle counter reaches TIMEOUT (TIMEOUT != 0), flush_pend SHALL set exactly as a flush would.
REQ-025 If flush arrives in the same cycle as an accepted beat, the beat SHALL be counted first. If that beat completes the word, the flush SHALL be ignored (cnt becomes 0).
REQ-026 Latency: the last beat is accepted at edge N; the word is visible at o_valid from edge N. A flush pulse sampled at edge N yields a word at edge N+1 when out_free holds.
REQ-027 A back-to-back output transfer and load in the same cycle SHALL be supported without a bubble.

Reset
REQ-028 On rst_n=0, asynchronously: o_valid=0, o_data=0, o_keep=0, o_last=0, cnt=0, flush_pend=0, idle counter=0. r_en SHALL then evaluate to 1.
REQ-029 A reset asserted mid-word SHALL discard partial lanes and any pending word. After release, packing SHALL resume at lane 0.

Verification
REQ-030 Streaming: with o_ready=1, feed bytes 0x11,0x22,0x33,0x44,0x55 -> one word o_data=0x44332211, o_keep=0xF, o_last=0; r_en stays 1 throughout.
REQ-031 Flush: feed 0xAA,0xBB, then pulse flush -> o_data=0x0000BBAA, o_keep=0x3, o_last=1; a following flush pulse with cnt=0 produces no word.
REQ-032 Backpressure: hold o_ready=0 and feed 9 beats -> the first word is held stable; r_en drops to 0 with cnt=3. Releasing o_ready drains words in order with no loss or duplication.
REQ-033 Timeout: TIMEOUT=4, feed one byte 0x5A, then idle -> the word appears within 6 cycles with o_keep=0x1 and o_last=1. With TIMEOUT=0, no word ever appears.
REQ-034 Collision: a flush arrives in the same cycle as the 4th beat -> exactly one full word with o_last=0 and no extra partial word.
REQ-035 Integration: connect to the async FIFO (wclk 100 MHz, rclk 73 MHz) and push 1000 random bytes with random o_ready -> the packed output byte stream equals the input byte stream exactly.

Source files
------------

// File: rtl/stream_width_packer.sv
// Packs RATIO narrow beats from an async FIFO read port into one wide word.
// Partial words are emitted on an explicit flush or after TIMEOUT idle cycles.
module stream_width_packer #(
  parameter int DSIZE   = 8,
  parameter int RATIO   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                   rclk,
  input  logic                   rst_n,
  input  logic [DSIZE-1:0]       rdata,
  input  logic                   r_ok,
  output logic                   r_en,
  input  logic                   flush,
  output logic [DSIZE*RATIO-1:0] o_data,
  output logic [RATIO-1:0]       o_keep,
  output logic                   o_last,
  output logic                   o_valid,
  input  logic                   o_ready
);

  localparam int              CW        = $clog2(RATIO);
  localparam int              WW        = DSIZE * RATIO;
  localparam logic [CW-1:0]   LAST_LANE = CW'(RATIO - 1);
  localparam logic [15:0]     TMO       = 16'(TIMEOUT);

  logic [CW-1:0]    cnt_q, cnt_d;
  logic             flush_pend_q, flush_pend_d;
  logic [15:0]      idle_q, idle_d;
  logic [WW-1:0]    acc_q, acc_d;
  logic [WW-1:0]    data_q, data_d;
  logic [RATIO-1:0] keep_q, keep_d;
  logic             last_q, last_d;
  logic             valid_q, valid_d;

  logic out_free, beat, full_load, flush_load, timeout_hit;

  assign out_free    = ~valid_q | o_ready;
  assign r_en        = ~flush_pend_q & ((cnt_q != LAST_LANE) | out_free);
  assign beat        = r_ok & r_en;
  assign full_load   = beat & (cnt_q == LAST_LANE);
  assign flush_load  = flush_pend_q & out_free;
  assign timeout_hit = (TIMEOUT != 0) && (idle_q == TMO);

  always_comb begin
    cnt_d        = cnt_q;
    acc_d        = acc_q;
    flush_pend_d = flush_pend_q;
    idle_d       = idle_q;
    valid_d      = valid_q & ~o_ready;
    data_d       = data_q;
    keep_d       = keep_q;
    last_d       = last_q;

    // The top lane never lives in acc: the completing beat goes straight out.
    if (full_load) begin
      cnt_d                     = '0;
      data_d                    = acc_q;
      data_d[WW-DSIZE +: DSIZE] = rdata;
      keep_d                    = '1;
      last_d                    = 1'b0;
      valid_d                   = 1'b1;
      acc_d                     = '0;
    end else if (beat) begin
      cnt_d = cnt_q + 1'b1;
      for (int i = 0; i < RATIO; i++) begin
        if (cnt_q == CW'(i)) acc_d[i*DSIZE +: DSIZE] = rdata;
      end
    end else if (flush_load) begin
      cnt_d   = '0;
      data_d  = acc_q;
      for (int i = 0; i < RATIO; i++) begin
        keep_d[i] = (CW'(i) < cnt_q);
      end
      last_d       = 1'b1;
      valid_d      = 1'b1;
      acc_d        = '0;
      flush_pend_d = 1'b0;
    end

    // Evaluated on the post-beat lane count so a completing beat swallows the flush.
    if ((flush | timeout_hit) && (cnt_d != '0)) flush_pend_d = 1'b1;

    if (beat || (cnt_q == '0)) begin
      idle_d = '0;
    end else if (!flush_pend_q && (idle_q != 16'hFFFF)) begin
      idle_d = idle_q + 16'd1;
    end
  end

  always_ff @(posedge rclk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      flush_pend_q <= 1'b0;
      idle_q       <= '0;
      acc_q        <= '0;
      data_q       <= '0;
      keep_q       <= '0;
      last_q       <= 1'b0;
      valid_q      <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      flush_pend_q <= flush_pend_d;
      idle_q       <= idle_d;
      acc_q        <= acc_d;
      data_q       <= data_d;
      keep_q       <= keep_d;
      last_q       <= last_d;
      valid_q      <= valid_d;
    end
  end

  assign o_data  = data_q;
  assign o_keep  = keep_q;
  assign o_last  = last_q;
  assign o_valid = valid_q;

endmodule

// File: tb/tb_stream_width_packer.sv
// Directed and randomized-stream bench for stream_width_packer (DSIZE=8, RATIO=4).
module tb_stream_width_packer;

  logic        rclk = 1'b0;
  logic        rst_n;
  logic [7:0]  rdata;
  logic        r_ok, flush, o_ready;
  logic        r_en;
  logic [31:0] o_data;
  logic [3:0]  o_keep;
  logic        o_last, o_valid;

  logic        r_ok_t4, r_ok_t0, no_flush;
  logic        r_en_t4, r_en_t0;
  logic [31:0] o_data_t4, o_data_t0;
  logic [3:0]  o_keep_t4, o_keep_t0;
  logic        o_last_t4, o_last_t0, o_valid_t4, o_valid_t0;
  logic        rdy_one;

  int checks   = 0;
  int failures = 0;

  always #5 rclk = ~rclk;

  stream_width_packer #(.DSIZE(8), .RATIO(4), .TIMEOUT(255)) dut (
    .rclk(rclk), .rst_n(rst_n), .rdata(rdata), .r_ok(r_ok), .r_en(r_en),
    .flush(flush), .o_data(o_data), .o_keep(o_keep), .o_last(o_last),
    .o_valid(o_valid), .o_ready(o_ready)
  );

  stream_width_packer #(.DSIZE(8), .RATIO(4), .TIMEOUT(4)) dut_t4 (
    .rclk(rclk), .rst_n(rst_n), .rdata(rdata), .r_ok(r_ok_t4), .r_en(r_en_t4),
    .flush(no_flush), .o_data(o_data_t4), .o_keep(o_keep_t4), .o_last(o_last_t4),
    .o_valid(o_valid_t4), .o_ready(rdy_one)
  );

  stream_width_packer #(.DSIZE(8), .RATIO(4), .TIMEOUT(0)) dut_t0 (
    .rclk(rclk), .rst_n(rst_n), .rdata(rdata), .r_ok(r_ok_t0), .r_en(r_en_t0),
    .flush(no_flush), .o_data(o_data_t0), .o_keep(o_keep_t0), .o_last(o_last_t0),
    .o_valid(o_valid_t0), .o_ready(rdy_one)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge rclk);
    #1;
  endtask

  task automatic beat(input logic [7:0] d);
    rdata = d;
    r_ok  = 1'b1;
    #1;
    chk("r_en_beat", {31'd0, r_en}, 32'd1);
    tick();
    r_ok = 1'b0;
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  initial begin
    logic [7:0] q[$];
    logic [7:0] exp_b;
    int sent, recv, cyc, seen;
    logic [31:0] cap_data;
    logic [3:0]  cap_keep;
    logic        cap_last;

    rst_n = 1'b0; rdata = '0; r_ok = 0; flush = 0; o_ready = 1;
    r_ok_t4 = 0; r_ok_t0 = 0; no_flush = 0; rdy_one = 1;
    #2;
    chk("rst_valid", {31'd0, o_valid}, 32'd0);
    chk("rst_data",  o_data, 32'd0);
    chk("rst_keep",  {28'd0, o_keep}, 32'd0);
    chk("rst_last",  {31'd0, o_last}, 32'd0);
    chk("rst_ren",   {31'd0, r_en}, 32'd1);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // streaming
    beat(8'h11); beat(8'h22); beat(8'h33);
    chk("str_novalid", {31'd0, o_valid}, 32'd0);
    beat(8'h44);
    chk("str_valid", {31'd0, o_valid}, 32'd1);
    chk("str_data",  o_data, 32'h44332211);
    chk("str_keep",  {28'd0, o_keep}, 32'hF);
    chk("str_last",  {31'd0, o_last}, 32'd0);
    beat(8'h55);
    chk("str_drained", {31'd0, o_valid}, 32'd0);
    pulse_flush();
    chk("str_flush_pend", {31'd0, o_valid}, 32'd0);
    tick();
    chk("str_tail_valid", {31'd0, o_valid}, 32'd1);
    chk("str_tail_data",  o_data, 32'h00000055);
    chk("str_tail_keep",  {28'd0, o_keep}, 32'h1);
    chk("str_tail_last",  {31'd0, o_last}, 32'd1);

    // flush of a two-lane partial word, then flush with nothing pending
    beat(8'hAA); beat(8'hBB);
    pulse_flush();
    tick();
    chk("fl_valid", {31'd0, o_valid}, 32'd1);
    chk("fl_data",  o_data, 32'h0000BBAA);
    chk("fl_keep",  {28'd0, o_keep}, 32'h3);
    chk("fl_last",  {31'd0, o_last}, 32'd1);
    pulse_flush();
    chk("fl_empty0", {31'd0, o_valid}, 32'd0);
    tick();
    chk("fl_empty1", {31'd0, o_valid}, 32'd0);
    tick();
    chk("fl_empty2", {31'd0, o_valid}, 32'd0);

    // backpressure
    o_ready = 1'b0;
    for (int i = 1; i <= 7; i++) beat(8'(i));
    rdata = 8'h08; r_ok = 1'b1;
    #1;
    chk("bp_ren_low", {31'd0, r_en}, 32'd0);
    chk("bp_hold_data", o_data, 32'h04030201);
    tick(); tick();
    chk("bp_hold_data2", o_data, 32'h04030201);
    chk("bp_hold_keep",  {28'd0, o_keep}, 32'hF);
    chk("bp_hold_valid", {31'd0, o_valid}, 32'd1);
    chk("bp_ren_still",  {31'd0, r_en}, 32'd0);
    o_ready = 1'b1;
    #1;
    chk("bp_ren_release", {31'd0, r_en}, 32'd1);
    tick();
    chk("bp_w2_valid", {31'd0, o_valid}, 32'd1);
    chk("bp_w2_data",  o_data, 32'h08070605);
    r_ok = 1'b0;
    beat(8'h09);
    chk("bp_w2_gone", {31'd0, o_valid}, 32'd0);
    pulse_flush();
    tick();
    chk("bp_w3_data", o_data, 32'h00000009);
    chk("bp_w3_keep", {28'd0, o_keep}, 32'h1);
    tick();

    // collision of flush with the completing beat
    beat(8'hC1); beat(8'hC2); beat(8'hC3);
    rdata = 8'hC4; r_ok = 1'b1; flush = 1'b1;
    tick();
    r_ok = 1'b0; flush = 1'b0;
    chk("col_valid", {31'd0, o_valid}, 32'd1);
    chk("col_data",  o_data, 32'hC4C3C2C1);
    chk("col_last",  {31'd0, o_last}, 32'd0);
    tick();
    chk("col_none1", {31'd0, o_valid}, 32'd0);
    tick();
    chk("col_none2", {31'd0, o_valid}, 32'd0);

    // reset mid-word discards stale lanes
    beat(8'hE1); beat(8'hE2); beat(8'hE3);
    rst_n = 1'b0;
    #1;
    chk("mr_valid", {31'd0, o_valid}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    beat(8'h77);
    pulse_flush();
    tick();
    chk("mr_data", o_data, 32'h00000077);
    chk("mr_keep", {28'd0, o_keep}, 32'h1);
    tick();

    // timeout enabled (4) and disabled (0)
    rdata = 8'h5A; r_ok_t4 = 1'b1; r_ok_t0 = 1'b1;
    tick();
    r_ok_t4 = 1'b0; r_ok_t0 = 1'b0;
    seen = 0; cap_data = '0; cap_keep = '0; cap_last = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (o_valid_t4 && seen == 0) begin
        seen = 1; cap_data = o_data_t4; cap_keep = o_keep_t4; cap_last = o_last_t4;
      end
    end
    chk("to_seen", 32'(seen), 32'd1);
    chk("to_data", cap_data, 32'h0000005A);
    chk("to_keep", {28'd0, cap_keep}, 32'h1);
    chk("to_last", {31'd0, cap_last}, 32'd1);
    seen = 0;
    for (int k = 0; k < 300; k++) begin
      tick();
      if (o_valid_t0) seen = 1;
    end
    chk("to0_never", 32'(seen), 32'd0);

    // random stream: output byte stream must equal input byte stream
    sent = 0; recv = 0; cyc = 0;
    while (sent < 1000 && cyc < 20000) begin
      rdata   = 8'($urandom);
      r_ok    = ($urandom_range(0, 3) != 0);
      o_ready = ($urandom_range(0, 2) != 0);
      flush   = ($urandom_range(0, 19) == 0);
      #1;
      if (r_ok && r_en) begin q.push_back(rdata); sent++; end
      if (o_valid && o_ready) begin
        for (int l = 0; l < 4; l++) begin
          if (o_keep[l]) begin
            exp_b = (q.size() > 0) ? q.pop_front() : 8'hXX;
            chk("rnd_byte", {24'd0, o_data[l*8 +: 8]}, {24'd0, exp_b});
            recv++;
          end
        end
      end
      tick();
      cyc++;
    end
    chk("rnd_budget", {31'd0, (sent >= 1000)}, 32'd1);
    r_ok = 1'b0; o_ready = 1'b1; flush = 1'b0;
    for (int k = 0; k < 20; k++) begin
      flush = (k == 2);
      #1;
      if (o_valid && o_ready) begin
        for (int l = 0; l < 4; l++) begin
          if (o_keep[l]) begin
            exp_b = (q.size() > 0) ? q.pop_front() : 8'hXX;
            chk("rnd_tail", {24'd0, o_data[l*8 +: 8]}, {24'd0, exp_b});
            recv++;
          end
        end
      end
      tick();
    end
    chk("rnd_queue_empty", 32'(q.size()), 32'd0);
    chk("rnd_count", 32'(recv), 32'(sent));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
